// File: rtl/tile_vector_driver_if.sv
// Controller-side bundle for tile_vector_driver: run request, run parameters
// and completion status.
interface tile_vector_driver_if;
  logic        start;
  logic        mode;
  logic [7:0]  seed;
  logic [8:0]  count;
  logic [15:0] expected_sig;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic        pass;

  modport master (
    output start, mode, seed, count, expected_sig,
    input  busy, done, signature, pass
  );

  modport slave (
    input  start, mode, seed, count, expected_sig,
    output busy, done, signature, pass
  );
endinterface

// File: rtl/tile_vector_driver.sv
// Drives a combinational microtile with a counter/LFSR vector sequence and
// folds each response into a 16-bit MISR, comparing against a golden value.
module tile_vector_driver #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  tile_vector_driver_if.slave  ctl,
  output logic [7:0]           tile_ui_in,
  input  logic [7:0]           tile_uo_out
);

  typedef enum logic {IDLE, DRIVE} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t      state;
  logic        lat_mode;
  logic [15:0] lat_exp;
  logic [8:0]  remaining;
  logic [3:0]  settle;
  logic [15:0] sig_next;

  function automatic logic [7:0] advance(input logic m, input logic [7:0] v);
    if (m) advance = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    else   advance = v + 8'd1;
  endfunction

  always_comb begin
    sig_next = {ctl.signature[14:0],
                ctl.signature[15] ^ ctl.signature[13] ^
                ctl.signature[12] ^ ctl.signature[10]} ^ {8'h00, tile_uo_out};
  end

  // tile_ui_in doubles as the current-vector register; it is zeroed in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_mode      <= 1'b0;
      lat_exp       <= '0;
      remaining     <= '0;
      settle        <= '0;
      tile_ui_in    <= '0;
      ctl.busy      <= 1'b0;
      ctl.done      <= 1'b0;
      ctl.signature <= '0;
      ctl.pass      <= 1'b0;
    end else begin
      ctl.done <= 1'b0;
      case (state)
        IDLE: begin
          if (ctl.start) begin
            ctl.signature <= '1;
            if (ctl.count == '0) begin
              ctl.pass <= (ctl.expected_sig == '1);
              ctl.done <= 1'b1;
            end else begin
              lat_mode   <= ctl.mode;
              lat_exp    <= ctl.expected_sig;
              remaining  <= ctl.count;
              settle     <= SETTLE_INIT;
              tile_ui_in <= (ctl.mode && ctl.seed == '0) ? 8'h01 : ctl.seed;
              ctl.pass   <= 1'b0;
              ctl.busy   <= 1'b1;
              state      <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (settle != '0) begin
            settle <= settle - 4'd1;
          end else begin
            ctl.signature <= sig_next;
            remaining     <= remaining - 9'd1;
            if (remaining == 9'd1) begin
              state      <= IDLE;
              tile_ui_in <= '0;
              ctl.busy   <= 1'b0;
              ctl.done   <= 1'b1;
              ctl.pass   <= (sig_next == lat_exp);
            end else begin
              tile_ui_in <= advance(lat_mode, tile_ui_in);
              settle     <= SETTLE_INIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
